// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - driver-side byte pop handshake and status of the PS/2 receiver
interface ps2_rx_fifo_if;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport master (
        output nextdata_n,
        input  data,
        input  ready,
        input  overflow,
        input  frame_err
    );

    modport slave (
        input  nextdata_n,
        output data,
        output ready,
        output overflow,
        output frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host deframer feeding a small byte FIFO
// Define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_rx_fifo #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         CLOCK_50,
    input  logic         clrn,
    input  logic         PS2_CLK,
    input  logic         PS2_DAT,
    ps2_rx_fifo_if.slave host
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    logic               clk_s1, clk_s2, clk_prev;
    logic               dat_s1, dat_s2;
    logic [3:0]         bitcnt;
    logic [9:0]         sr;
    logic [TW-1:0]      tcnt;
    logic [FIFO_AW:0]   wptr, rptr;
    logic [7:0]         mem [DEPTH];
    logic               overflow_q, frame_err_q;

    logic fall, stop_fall, parity_ok, frame_ok, empty, full, pop, push;

    always_ff @(posedge CLOCK_50 or negedge clrn) begin
        if (!clrn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
        end
    end

    assign fall      = clk_prev & ~clk_s2;
    assign stop_fall = fall && (bitcnt == 4'd10);

    // sr[0] holds the start bit, sr[8:1] the byte, sr[9] parity; stop is the live sample.
`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^sr[9:1];
`else
    logic unused_parity;
    assign unused_parity = sr[9];
    assign parity_ok     = 1'b1;
`endif
    assign frame_ok = ~sr[0] & dat_s2 & parity_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]) && (wptr[FIFO_AW] != rptr[FIFO_AW]);
    assign pop   = ~host.nextdata_n & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = stop_fall && frame_ok && (!full || pop);

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wptr[FIFO_AW-1:0]] <= sr[8:1];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge clrn) begin
        if (!clrn) begin
            bitcnt      <= 4'd0;
            sr          <= 10'd0;
            tcnt        <= '0;
            wptr        <= '0;
            rptr        <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (fall) begin
                tcnt <= '0;
                if (bitcnt == 4'd10) begin
                    bitcnt <= 4'd0;
                    if (!frame_ok) begin
                        frame_err_q <= 1'b1;
                    end else if (full && !pop) begin
                        overflow_q <= 1'b1;
                    end
                end else begin
                    sr     <= {dat_s2, sr[9:1]};
                    bitcnt <= bitcnt + 4'd1;
                end
            end else if (bitcnt != 4'd0) begin
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    tcnt        <= '0;
                    bitcnt      <= 4'd0;
                    frame_err_q <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

    assign host.data      = mem[rptr[FIFO_AW-1:0]];
    assign host.ready     = ~empty;
    assign host.overflow  = overflow_q;
    assign host.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed bench for ps2_rx_fifo with a queue-based reference model
module tb_ps2_rx_fifo;
    localparam int TMO = 50000;
    localparam int H   = 8;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_rx_fifo_if bus();

    ps2_rx_fifo #(.FIFO_AW(3), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50 (clk),
        .clrn     (clrn),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .host     (bus)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ev_at = -1;
    bit ev_push = 1'b0;
    logic [7:0] ev_byte = 8'h00;
    logic [7:0] q[$];
    bit m_ovf = 1'b0;
    bit m_err = 1'b0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // Reference: FIFO as a queue; frame outcomes land 3 cycles after the pin fall.
    initial begin
        nextdata_init();
        forever begin
            @(posedge clk);
            cyc++;
            if (clrn) begin
                m_err = 1'b0;
                if (!bus.nextdata_n && q.size() != 0) void'(q.pop_front());
                if (cyc == ev_at) begin
                    ev_at = -1;
                    if (!ev_push) m_err = 1'b1;
                    else if (q.size() < 8) q.push_back(ev_byte);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic nextdata_init();
        bus.nextdata_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus.frame_err === 1'b1) err_cnt++;
            chk("ready", 32'(bus.ready), 32'(q.size() != 0));
            if (q.size() != 0) chk("data", 32'(bus.data), 32'(q[0]));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("frame_err", 32'(bus.frame_err), 32'(m_err));
        end
    end

    // sched: 0 none, 1 frame outcome, 2 timeout of a partial frame
    task automatic ps2_bit(input bit b, input int sched, input bit pop_here);
        ps2_dat = b;
        repeat (H) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (sched == 1) ev_at = cyc + 3;
        else if (sched == 2) ev_at = cyc + 3 + TMO;
        if (pop_here) begin
            repeat (2) @(posedge clk);
            #1 bus.nextdata_n = 1'b0;
            @(posedge clk);
            #1 bus.nextdata_n = 1'b1;
            repeat (H - 3) @(posedge clk);
        end else begin
            repeat (H) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par, input bit stop, input bit pop_last);
        logic [10:0] f;
        f = {stop, par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
        ev_push = stop && ((^b ^ par) == 1'b1);
`else
        ev_push = stop;
`endif
        ev_byte = b;
        for (int i = 0; i < 11; i++) ps2_bit(f[i], (i == 10) ? 1 : 0, pop_last && (i == 10));
    endtask

    task automatic send_partial(input int n);
        logic [10:0] f;
        f = {1'b1, 1'b0, 8'h1C, 1'b0};
        ev_push = 1'b0;
        for (int i = 0; i < n; i++) ps2_bit(f[i], (i == n - 1) ? 2 : 0, 1'b0);
    endtask

    task automatic pop1();
        bus.nextdata_n = 1'b0;
        @(posedge clk);
        #1 bus.nextdata_n = 1'b1;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        ev_at = -1;
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_ready", 32'(bus.ready), 32'd0);
        chk("init_overflow", 32'(bus.overflow), 32'd0);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("t1_ready", 32'(bus.ready), 32'd1);
        chk("t1_data", 32'(bus.data), 32'h1C);
        pop1();
        chk("t1_empty", 32'(bus.ready), 32'd0);

        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("t2_data0", 32'(bus.data), 32'hF0);
        pop1();
        chk("t2_data1", 32'(bus.data), 32'h1C);
        pop1();
        chk("t2_empty", 32'(bus.ready), 32'd0);
        chk("t2_overflow", 32'(bus.overflow), 32'd0);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 1'b0);
        chk("t3_overflow", 32'(bus.overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_order", 32'(bus.data), 32'(i));
            pop1();
        end
        chk("t3_empty", 32'(bus.ready), 32'd0);
        chk("t3_sticky", 32'(bus.overflow), 32'd1);

        do_reset();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 1'b0);
        send_frame(8'd9, odd_par(8'd9), 1'b1, 1'b1);
        chk("t4_overflow", 32'(bus.overflow), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            chk("t4_order", 32'(bus.data), 32'(i));
            pop1();
        end
        chk("t4_empty", 32'(bus.ready), 32'd0);

        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        chk("t5_err", 32'(err_cnt), 32'(e0 + 1));
        chk("t5_ready", 32'(bus.ready), 32'd0);
`else
        chk("t5_err", 32'(err_cnt), 32'(e0));
        chk("t5_data", 32'(bus.data), 32'h1C);
        pop1();
`endif

        e0 = err_cnt;
        send_frame(8'h55, odd_par(8'h55), 1'b0, 1'b0);
        chk("t6_err", 32'(err_cnt), 32'(e0 + 1));
        chk("t6_ready", 32'(bus.ready), 32'd0);

        e0 = err_cnt;
        send_partial(5);
        repeat (TMO - 30) @(posedge clk);
        #1 chk("t7_no_early_err", 32'(err_cnt), 32'(e0));
        repeat (50) @(posedge clk);
        #1 chk("t7_err", 32'(err_cnt), 32'(e0 + 1));
        chk("t7_ready", 32'(bus.ready), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("t7_data", 32'(bus.data), 32'h1C);
        pop1();

        send_frame(8'h11, odd_par(8'h11), 1'b1, 1'b0);
        send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b0);
        chk("t8_ready", 32'(bus.ready), 32'd1);
        send_partial(6);
        do_reset();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        chk("t8_data", 32'(bus.data), 32'hF0);
        pop1();
        chk("t8_empty", 32'(bus.ready), 32'd0);
        chk("t8_overflow", 32'(bus.overflow), 32'd0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host receiver feeding the keyboard driver: it oversamples the keyboard's PS/2 clock and data lines on the 50 MHz system clock and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Each valid scan-code byte goes into a small FIFO. The driver reads bytes through a ready/nextdata_n pop handshake. The block is receive-only and never drives the PS/2 lines.

## Interface
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW entries (8).
- TIMEOUT_CYCLES, 50000: idle CLOCK_50 cycles inside a partial frame before it is abandoned (1 ms at 50 MHz).
- CLOCK_50  input  1  system clock, all logic on posedge.
- clrn  input  1  reset, asynchronous, active-low.
- PS2_CLK  input  1  raw keyboard clock, asynchronous.
- PS2_DAT  input  1  raw keyboard data, asynchronous.
- nextdata_n  input  1  active-low pop request from the driver.
- data  output  8  byte at FIFO head; valid while ready=1.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky: a valid frame arrived while the FIFO was full.
- frame_err  output  1  one-cycle pulse: a frame was rejected.

## Operation
- Sync: PS2_CLK and PS2_DAT each pass through 2 flops. A third PS2_CLK history flop provides edge detection. The falling edge is `fall = prev & ~cur`. PS2_DAT is sampled from its synchronised value on the fall cycle.
- Deframer: 4-bit bit counter `bitcnt` (0..10) and 10-bit shift register.
  - Each fall shifts the bit in, then `bitcnt++`.
  - On the fall with bitcnt==10, the frame is checked and `bitcnt` returns to 0.
- Frame check:
  - start==0, stop==1, and the parity rule (see Configuration).
  - Pass: push the data byte.
  - Fail: drop the byte and pulse frame_err.
- Timeout:
  - A counter clears on every fall and counts while bitcnt!=0.
  - On reaching TIMEOUT_CYCLES: bitcnt returns to 0, the partial frame is discarded, and frame_err pulses.
  - No timeout while bitcnt==0.
- FIFO: circular, with read/write pointers of FIFO_AW+1 bits (wrap bit distinguishes full from empty).
  - empty when pointers are equal; full when the low bits are equal and the wrap bits differ.
  - data = mem[rptr[FIFO_AW-1:0]], combinational from registered storage.
- Pop: on each posedge with nextdata_n==0 and ready==1, rptr increments. nextdata_n==0 while empty is ignored. Holding nextdata_n low pops one byte per cycle.
- Push when full:
  - Without a simultaneous pop: byte dropped, overflow set.
  - With a simultaneous pop: push and pop both complete, count unchanged, overflow not set.
- overflow clears only on reset.
- Reset (clrn=0, any time, including mid-frame):
  - pointers and bitcnt = 0, timeout counter = 0, sync flops = 1.
  - ready=0, overflow=0, frame_err=0, data=mem[0]; memory contents don't care.

## Timing
- PS2_CLK falling edge at the pin to fall pulse: 3 CLOCK_50 cycles (2 sync + 1 edge).
- Stop-bit fall cycle: push registered. ready=1 and data valid on the next cycle.
- Pop registered at the posedge where nextdata_n==0. ready/data reflect the new head in the following cycle.
- frame_err is high for exactly one cycle: the cycle after the failing stop-bit fall, or the cycle after the timeout hit.

## Configuration
- PS2_PARITY_CHECK_EN
  - Defined: the frame must have odd parity over 8 data bits plus the parity bit; otherwise it is rejected with frame_err.
  - Undefined: the parity bit is shifted in and ignored; only start/stop are checked.

## Test plan
- Frame for 0x1C (bits 0,0,0,1,1,1,0,0,0,P=0,1) -> ready=1, data=0x1C one cycle after the stop fall; nextdata_n low 1 cycle -> ready=0.
- Frames 0xF0 (P=1) then 0x1C back to back -> data=0xF0, pop, data=0x1C, pop, ready=0; overflow=0.
- Push 9 valid frames with no pops -> 8 stored, overflow=1 sticky, FIFO order preserved 1..8. Same test with a pop coinciding with the 9th push -> overflow stays 0.
- 0x1C with P=1 -> with PS2_PARITY_CHECK_EN: frame_err pulse, ready=0; without it: data=0x1C.
- Send 5 bits, idle 50000 cycles -> frame_err pulse, bitcnt=0; next full frame 0x1C is received correctly.
- Assert clrn=0 after 6 bits with FIFO holding 2 bytes -> ready=0, overflow=0 immediately; after release, frame 0xF0 gives data=0xF0.
